mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin grant arbiter for the shared memory port, with an OA-writer boost
// when the output FIFO is full and a hold watchdog that reclaims stuck grants.
module mem_port_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int REG_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   done,
  input  logic                 fifo_full_flag,
  input  logic                 clear_err,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [2:0]           icb_sel,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [REG_WIDTH-1:0] grant_count
);

  localparam int IW     = $clog2(NUM_REQ);
  localparam int HW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int OA_IDX = 4;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                 state_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [2:0]             sel_q;
  logic                   err_q;
  logic [REG_WIDTH-1:0]   cnt_q;
  logic [HW-1:0]          hold_q;
  logic [IW-1:0]          last_q;
  logic                   init_q;

  logic                   oa_boost;
  logic                   found;
  logic [IW-1:0]          cand;
  logic [IW-1:0]          win_d;
  logic [NUM_REQ-1:0]     gnt_d;

  if (NUM_REQ > OA_IDX) begin : g_oa
    assign oa_boost = fifo_full_flag & req[OA_IDX];
  end else begin : g_no_oa
    assign oa_boost = 1'b0;
  end

  // Search starts one past the last winner and wraps around.
  always_comb begin
    win_d = last_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
    if (oa_boost) win_d = IW'(OA_IDX);
  end

  always_comb begin
    gnt_d        = '0;
    gnt_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      init_q  <= 1'b1;
    end else begin
      init_q <= 1'b0;
      if (clear_err) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // init_q suppresses a grant on the first edge after reset release.
          if (arb_en && (|req) && !init_q) begin
            gnt_q   <= gnt_d;
            sel_q   <= 3'(win_d);
            last_q  <= win_d;
            hold_q  <= '0;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (|(done & gnt_q)) begin
            gnt_q   <= '0;
            state_q <= GAP;
          end else if ((TIMEOUT > 0) && (hold_q == HW'(TIMEOUT - 1))) begin
            gnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= GAP;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign icb_sel     = sel_q;
  assign busy        = |gnt_q;
  assign timeout_err = err_q;
  assign grant_count = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: owner/phase reference model checked every cycle,
// directed scenarios with literal expectations, then a sticky-request stress run.
module tb_mem_port_arbiter;

  localparam int N  = 5;
  localparam int RW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arb_en = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  done = '0;
  logic          fifo = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  gnt;
  logic [2:0]    icb_sel;
  logic          busy;
  logic          timeout_err;
  logic [RW-1:0] grant_count;

  int pass_n = 0;
  int total_n = 0;

  mem_port_arbiter #(.NUM_REQ(N), .REG_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .done(done),
    .fifo_full_flag(fifo), .clear_err(clr), .gnt(gnt), .icb_sel(icb_sel),
    .busy(busy), .timeout_err(timeout_err), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: who owns the port, whether we are in the post-release gap,
  // and the round-robin pointer. Updated from the inputs seen at each rising edge.
  int  m_owner = -1;
  bit  m_gap = 0;
  int  m_last = N - 1;
  int  m_hold = 0;
  bit  m_err = 0;
  int  m_count = 0;
  int  m_sel = 0;
  bit  m_fresh = 1;
  bit  started = 0;
  int  wait_n[N];

  always @(posedge clk) begin
    bit set_e;
    bit ovr;
    int w;
    started = 1;
    if (rst) begin
      m_owner = -1; m_gap = 0; m_last = N - 1; m_hold = 0;
      m_err = 0; m_count = 0; m_sel = 0; m_fresh = 1;
      for (int i = 0; i < N; i++) wait_n[i] = 0;
    end else begin
      set_e = 0;
      for (int i = 0; i < N; i++) if (!req[i]) wait_n[i] = 0;
      if (m_owner >= 0) begin
        if (done[m_owner]) begin
          m_owner = -1; m_gap = 1;
        end else if (m_hold == TO - 1) begin
          m_owner = -1; m_gap = 1; set_e = 1;
        end else begin
          m_hold++;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (!m_fresh && arb_en && req != 0) begin
        ovr = fifo && req[4];
        w = -1;
        if (ovr) w = 4;
        else for (int k = 1; k <= N; k++)
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        m_owner = w; m_sel = w; m_last = w; m_hold = 0;
        m_count = (m_count + 1) % (1 << RW);
        // Consecutive round-robin grants a pending requester has watched go elsewhere.
        for (int i = 0; i < N; i++) begin
          if (ovr || i == w) wait_n[i] = 0;
          else if (req[i]) begin
            wait_n[i]++;
            chk("starvation", 32'(wait_n[i] < N), 1);
          end
        end
      end
      m_fresh = 0;
      if (set_e) m_err = 1;
      else if (clr) m_err = 0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_gnt;
    if (started) begin
      exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("icb_sel", 32'(icb_sel), m_sel);
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      chk("grant_count", 32'(grant_count), m_count);
      chk("onehot", 32'($onehot0(gnt)), 1);
    end
  end

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        break;
      end
    end
    if (idx < 0) chk("wait_gnt_timeout", 0, 1);
  endtask

  task automatic release_port(input int idx);
    if (idx >= 0) done[idx] = 1'b1;
    req = '0;
    @(negedge clk);
    done = '0;
    repeat (3) @(negedge clk);
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    int w;
    int hi;
    // Reset state
    arb_en = 1'b1;
    req = 5'b11111;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_sel", 32'(icb_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_count", 32'(grant_count), 0);
    rst = 1'b0;

    // Round-robin order with all requesters pending, done 3 cycles after gnt
    for (int k = 0; k < 6; k++) begin
      wait_gnt(w);
      chk("rr_order", w, exp_order[k]);
      chk("rr_sel", 32'(icb_sel), w);
      repeat (2) @(negedge clk);
      if (w >= 0) done[w] = 1'b1;
      if (k == 5) req = '0;
      @(negedge clk);
      done = '0;
    end
    chk("rr_count", 32'(grant_count), 6);
    repeat (3) @(negedge clk);

    // Park the pointer on 4 so plain round-robin would pick 0 next
    req = 5'b10000;
    wait_gnt(w);
    release_port(w);
    req = 5'b10001;
    fifo = 1'b1;
    wait_gnt(w);
    chk("ovr_gnt", 32'(gnt), 32'(5'b10000));
    chk("ovr_sel", 32'(icb_sel), 4);
    fifo = 1'b0;
    done[4] = 1'b1;
    @(negedge clk);
    done = '0;
    wait_gnt(w);
    chk("ovr_next_rr", w, 0);
    release_port(w);

    // Watchdog: dropped req without done keeps the grant; stray done ignored
    req = 5'b00100;
    wait_gnt(w);
    chk("to_idx", w, 2);
    req = '0;
    hi = 1;
    for (int c = 0; c < 20; c++) begin
      done = (c == 2) ? 5'b00010 : 5'b00000;
      @(negedge clk);
      if (gnt == 0) break;
      hi++;
    end
    done = '0;
    chk("to_hold_cycles", hi, 8);
    chk("to_err_set", 32'(timeout_err), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 0);
    repeat (2) @(negedge clk);
    // done lands on the same edge the watchdog would fire
    req = 5'b00100;
    wait_gnt(w);
    req = '0;
    repeat (7) @(negedge clk);
    done = 5'b00100;
    @(negedge clk);
    done = '0;
    chk("done_vs_to_gnt", 32'(gnt), 0);
    chk("done_vs_to_err", 32'(timeout_err), 0);
    repeat (3) @(negedge clk);

    // arb_en gating
    arb_en = 1'b0;
    req = 5'b00010;
    repeat (10) @(negedge clk);
    chk("en_block", 32'(gnt), 0);
    arb_en = 1'b1;
    @(negedge clk);
    chk("en_grant", 32'(gnt), 32'(5'b00010));
    arb_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("en_hold", 32'(gnt), 32'(5'b00010));
    done = 5'b00010;
    req = '0;
    @(negedge clk);
    done = '0;
    chk("en_release", 32'(gnt), 0);
    arb_en = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a grant
    req = 5'b01000;
    wait_gnt(w);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_sel", 32'(icb_sel), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_grant", 32'(gnt), 0);
    @(negedge clk);
    chk("rst_regrant", 32'(gnt), 32'(5'b01000));
    release_port(3);

    // Stress: sticky requests dropped once granted, random done/flags
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      req    = (req & ~gnt) | (5'($urandom) & 5'($urandom));
      done   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
      fifo   = (c < 5000) && ($urandom_range(0, 7) == 0);
      arb_en = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    req = '0; done = '0; fifo = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
